// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M MUL/DIVU/REMU unit for the EX stage
// One shift-add or restoring-divide step per cycle; stalls the front end while busy.
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = XLEN
) (
    input  logic            clk_i,
    input  logic            start_i,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            busy_o
);

    localparam int CW = $clog2(ITER) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] F_MUL  = 3'b000;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REMU = 3'b111;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    // opa: multiplicand (MUL) or dividend in the low half (DIV); acc: product or {rem, quot}
    logic [2*XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_sub;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_nx;
    logic [XLEN-1:0]   quot_nx;
    logic [XLEN-1:0]   iter_res;
    logic              f3_ok;

    always_comb begin
        mul_acc  = acc_q + (opb_q[0] ? opa_q : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
        rem_sub  = rem_sh - {1'b0, opb_q};
        // A clear top bit means no borrow, i.e. the shifted remainder reached the divisor
        rem_ge   = ~rem_sub[XLEN];
        rem_nx   = rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
        quot_nx  = {acc_q[XLEN-2:0], rem_ge};
        if (f3_q == F_MUL) begin
            iter_res = mul_acc[XLEN-1:0];
        end else if (f3_q == F_DIVU) begin
            iter_res = quot_nx;
        end else begin
            iter_res = rem_nx;
        end
        f3_ok = (funct3_i == F_MUL) || (funct3_i == F_DIVU) || (funct3_i == F_REMU);
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    f3_d    = funct3_i;
                    rd_d    = rd_i;
                    opa_d   = {{XLEN{1'b0}}, rs1_data_i};
                    opb_d   = rs2_data_i;
                    acc_d   = '0;
                    count_d = '0;
                    if (!f3_ok) begin
                        result_d = '0;
                        rd_out_d = rd_i;
                        state_d  = S_DONE;
                    end else if (funct3_i == F_DIVU && rs2_data_i == '0) begin
                        result_d = '1;
                        rd_out_d = rd_i;
                        state_d  = S_DONE;
                    end else if (funct3_i == F_REMU && rs2_data_i == '0) begin
                        result_d = rs1_data_i;
                        rd_out_d = rd_i;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                count_d = count_q + 1'b1;
                opa_d   = opa_q << 1;
                if (f3_q == F_MUL) begin
                    acc_d = mul_acc;
                    opb_d = opb_q >> 1;
                end else begin
                    acc_d = {rem_nx, quot_nx};
                end
                if (count_q == CW'(ITER - 1)) begin
                    result_d = iter_res;
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    // Reset gates the stall so a held valid_i cannot freeze the pipeline during reset
    assign stall_o  = start_i & (((state_q == S_IDLE) & valid_i) | (state_q == S_BUSY));
    assign done_o   = (state_q == S_DONE);
    assign busy_o   = (state_q == S_BUSY);
    assign result_o = result_q;
    assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
// Directed and random ops compared against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        start_i;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;

    ex_muldiv_unit dut (
        .clk_i      (clk_i),
        .start_i    (start_i),
        .valid_i    (valid_i),
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_i       (rd_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_o       (rd_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (f3)
            3'b000: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b111:  return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_stalls(input logic [2:0] f3, input logic [31:0] b);
        if (f3 == 3'b000) return 33;
        if (f3 == 3'b101 || f3 == 3'b111) return (b == 0) ? 1 : 33;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input string tag);
        int stalls = 0;
        int busies = 0;
        int cyc = 0;
        bit got = 0;
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b; rd_i = rd;
        #1;
        while (!got && cyc < 100) begin
            if (stall_o) stalls++;
            if (busy_o) busies++;
            if (done_o) begin
                got = 1;
            end else begin
                @(negedge clk_i); #1;
                cyc++;
            end
        end
        valid_i = 1'b0;
        check({tag, " done"}, 64'(got), 64'd1);
        check({tag, " result"}, 64'(result_o), 64'(ref_result(f3, a, b)));
        check({tag, " rd"}, 64'(rd_o), 64'(rd));
        check({tag, " stalls"}, 64'(stalls), 64'(ref_stalls(f3, b)));
        check({tag, " busy"}, 64'(busies), 64'(ref_stalls(f3, b) - 1));
        @(negedge clk_i); #1;
        check({tag, " done pulse"}, 64'(done_o), 64'd0);
        check({tag, " result held"}, 64'(result_o), 64'(ref_result(f3, a, b)));
    endtask

    initial begin
        int ndone;
        int t1;
        int t2;
        int extra;
        logic [2:0] f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0] bad_codes [5];
        bad_codes[0] = 3'b001; bad_codes[1] = 3'b010; bad_codes[2] = 3'b011;
        bad_codes[3] = 3'b100; bad_codes[4] = 3'b110;

        start_i = 1'b0; valid_i = 1'b0; funct3_i = '0; rs1_data_i = '0; rs2_data_i = '0; rd_i = '0;
        repeat (3) @(negedge clk_i);
        start_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i); #1;
            check("idle stall", 64'(stall_o), 64'd0);
            check("idle done", 64'(done_o), 64'd0);
            check("idle busy", 64'(busy_o), 64'd0);
            check("idle result", 64'(result_o), 64'd0);
        end

        do_op(3'b000, 32'd7, 32'd6, 5'd3, "mul 7x6");
        do_op(3'b000, 32'hFFFF_FFFF, 32'd2, 5'd4, "mul ffffffff x2");
        do_op(3'b000, 32'h8000_0000, 32'h8000_0000, 5'd5, "mul 2^31 sq");
        do_op(3'b101, 32'd100, 32'd7, 5'd6, "divu 100/7");
        do_op(3'b111, 32'd100, 32'd7, 5'd7, "remu 100%7");
        do_op(3'b101, 32'd5, 32'd0, 5'd8, "divu by 0");
        do_op(3'b111, 32'd5, 32'd0, 5'd9, "remu by 0");
        do_op(3'b010, 32'd123, 32'd45, 5'd10, "unsupported 010");
        do_op(3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 5'd11, "divu big divisor");
        do_op(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 5'd12, "remu big divisor");

        // Back-to-back with valid_i held high through both operations
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = 3'b000; rs1_data_i = 32'd1234; rs2_data_i = 32'd5678; rd_i = 5'd13;
        #1;
        ndone = 0; t1 = -1; t2 = -1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (done_o) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = cyc;
                    check("b2b mul result", 64'(result_o), 64'(ref_result(3'b000, 32'd1234, 32'd5678)));
                    funct3_i = 3'b101; rs1_data_i = 32'd1000; rs2_data_i = 32'd33; rd_i = 5'd14;
                end else if (ndone == 2) begin
                    t2 = cyc;
                    check("b2b divu result", 64'(result_o), 64'(ref_result(3'b101, 32'd1000, 32'd33)));
                    check("b2b divu rd", 64'(rd_o), 64'd14);
                    valid_i = 1'b0;
                end
            end
            @(negedge clk_i); #1;
        end
        valid_i = 1'b0;
        check("b2b done count", 64'(ndone), 64'd2);
        check("b2b spacing", 64'(t2 - t1), 64'd34);

        // Abandon an op with reset in BUSY cycle 10
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = 3'b101; rs1_data_i = $urandom; rs2_data_i = 32'd3; rd_i = 5'd20;
        repeat (10) @(negedge clk_i);
        #1;
        check("pre-reset busy", 64'(busy_o), 64'd1);
        start_i = 1'b0;
        #1;
        check("reset stall", 64'(stall_o), 64'd0);
        check("reset done", 64'(done_o), 64'd0);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset result", 64'(result_o), 64'd0);
        check("reset rd", 64'(rd_o), 64'd0);
        valid_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i); #1;
            if (done_o) extra++;
        end
        check("no done after reset", 64'(extra), 64'd0);
        do_op(3'b000, 32'd11, 32'd13, 5'd21, "restart mul");

        for (int i = 0; i < 24; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) f3 = 3'b000;
            else if (r < 7) f3 = 3'b101;
            else if (r < 9) f3 = 3'b111;
            else f3 = bad_codes[$urandom_range(0, 4)];
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            do_op(f3, a, b, 5'($urandom_range(0, 31)), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
